// File: rtl/spi_bus_scheduler_if.sv
// Requester handshake and SPI pin bundle shared between spi_bus_scheduler and its users.
// The master modport is the scheduler's view; the slave modport is the requester/board view.
interface spi_bus_scheduler_if #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int NUM_SS   = 12,
    parameter int SS_IDX_W = 4
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*SS_IDX_W-1:0] req_ss;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ-1:0]          rsp_valid;
    logic                      rsp_err;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic [GID_W-1:0]          grant_id;
    logic                      spi_MISO;
    logic                      spi_MOSI;
    logic                      spi_SCLK;
    logic [NUM_SS-1:0]         spi_SS_n;

    modport master (
        input  req_valid, req_ss, req_wdata, spi_MISO,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, busy, grant_id,
               spi_MOSI, spi_SCLK, spi_SS_n
    );

    modport slave (
        output req_valid, req_ss, req_wdata, spi_MISO,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy, grant_id,
               spi_MOSI, spi_SCLK, spi_SS_n
    );
endinterface

// File: rtl/spi_bus_scheduler.sv
// Round-robin scheduler sharing one mode-0 SPI master between N_REQ requesters.
// Each grant runs one DATA_W-bit frame and returns the received word to its owner.
module spi_bus_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int NUM_SS   = 12,
    parameter int SS_IDX_W = 4,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    spi_bus_scheduler_if.master bus
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(2 * CLK_DIV + CS_SETUP) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [SS_IDX_W-1:0] ss_q, ss_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [GID_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;

    logic                grant_any;
    logic [GID_W-1:0]    gidx;
    logic [SS_IDX_W-1:0] sel_ss;
    logic [DATA_W-1:0]   sel_wdata;
    logic                ss_ok;
    logic                setup_end, shift_last, rise_cyc, last_high, last_bit, active_d;

    // Search starts at the requester after the last grant so every requester is served in turn.
    always_comb begin : arbiter
        logic [GID_W-1:0] cand;
        cand      = '0;
        grant_any = 1'b0;
        gidx      = '0;
        if (state_q == IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = GID_W'((int'(ptr_q) + i) % N_REQ);
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    gidx      = cand;
                end
            end
        end
    end

    assign sel_ss     = bus.req_ss[gidx*SS_IDX_W +: SS_IDX_W];
    assign sel_wdata  = bus.req_wdata[gidx*DATA_W +: DATA_W];
    assign ss_ok      = int'(sel_ss) < NUM_SS;
    assign setup_end  = cnt_q == CNT_W'(CS_SETUP - 1);
    assign shift_last = cnt_q == CNT_W'(2 * CLK_DIV - 1);
    assign rise_cyc   = cnt_q == '0;
    assign last_high  = cnt_q == CNT_W'(CLK_DIV - 1);
    assign last_bit   = bit_q == BIT_W'(DATA_W - 1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            ss_q        <= '0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            ss_n_q      <= '1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ss_q        <= ss_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            ss_n_q      <= ss_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ss_ok ? SETUP : DONE;
            SETUP:   if (setup_end) state_d = SHIFT;
            SHIFT:   if (shift_last && last_bit) state_d = HOLD;
            HOLD:    if (setup_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt_q times SETUP/HOLD and the 2*CLK_DIV cycles of each bit; bit_q counts finished bits.
    always_comb begin
        cnt_d       = '0;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        ss_d        = ss_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ss_d       = sel_ss;
                    tx_d       = sel_wdata;
                    rx_d       = '0;
                    bit_d      = '0;
                    grant_id_d = gidx;
                    ptr_d      = (gidx == GID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    if (!ss_ok) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: cnt_d = setup_end ? '0 : cnt_q + 1'b1;
            SHIFT: begin
                cnt_d = shift_last ? '0 : cnt_q + 1'b1;
                if (rise_cyc) rx_d = {rx_q[DATA_W-2:0], bus.spi_MISO};
                if (last_high && !last_bit) tx_d = {tx_q[DATA_W-2:0], 1'b0};
                if (shift_last) bit_d = bit_q + 1'b1;
            end
            HOLD: begin
                cnt_d = setup_end ? '0 : cnt_q + 1'b1;
                if (setup_end) begin
                    rsp_rdata_d = rx_q;
                    rsp_err_d   = 1'b0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Pins are decoded from next-state values so they leave flops glitch-free with no added latency.
    always_comb begin
        active_d    = state_d inside {SETUP, SHIFT, HOLD};
        ss_n_d      = '1;
        for (int j = 0; j < NUM_SS; j++) begin
            if (active_d && int'(ss_d) == j) ss_n_d[j] = 1'b0;
        end
        sclk_d      = (state_d == SHIFT) && (cnt_d < CNT_W'(CLK_DIV));
        mosi_d      = active_d & tx_d[DATA_W-1];
        rsp_valid_d = (state_d == DONE) ? (N_REQ'(1) << grant_id_d) : '0;
    end

    assign bus.req_ready = grant_any ? (N_REQ'(1) << gidx) : '0;
    assign bus.busy      = (state_q != IDLE) || grant_any;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.spi_SS_n  = ss_n_q;
    assign bus.spi_SCLK  = sclk_q;
    assign bus.spi_MOSI  = mosi_q;
endmodule
